debounce_input: RTL and testbench



---
 rtl/debounce_input.sv | 113 +++++++++++
 tb/tb_debounce_input.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_input.sv
// Per-channel 2-flop synchronizer plus tick-paced stability counter with press/release strobes.
// Optional long-press strobe is built only when DEBOUNCE_LONG_PRESS_EN is defined.
`timescale 1ns/1ps

module debounce_input #(
  parameter int unsigned NUM_CH       = 8,
  parameter int unsigned STABLE_TICKS = 16,
  parameter int unsigned LONG_TICKS   = 1000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              srst,
  input  logic              tick,
  input  logic [NUM_CH-1:0] raw_in,
  output logic [NUM_CH-1:0] level_out,
  output logic [NUM_CH-1:0] press_pulse,
  output logic [NUM_CH-1:0] release_pulse,
  output logic [NUM_CH-1:0] long_pulse
);

  localparam int unsigned CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [NUM_CH-1:0]         meta;
  logic [NUM_CH-1:0]         s;
  logic [NUM_CH-1:0][CW-1:0] cnt;
  logic [NUM_CH-1:0][CW-1:0] cnt_nxt;
  logic [NUM_CH-1:0]         accept;

  always_comb begin
    cnt_nxt = cnt;
    accept  = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (tick) begin
        if (s[i] == level_out[i]) begin
          cnt_nxt[i] = '0;
        end else if (cnt[i] == CNT_LAST) begin
          accept[i]  = 1'b1;
          cnt_nxt[i] = '0;
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta          <= '0;
      s             <= '0;
      cnt           <= '0;
      level_out     <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
    end else if (srst) begin
      meta          <= '0;
      s             <= '0;
      cnt           <= '0;
      level_out     <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
    end else begin
      meta          <= raw_in;
      s             <= meta;
      cnt           <= cnt_nxt;
      level_out     <= level_out ^ accept;
      press_pulse   <= accept & s;
      release_pulse <= accept & ~s;
    end
  end

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int unsigned LW = $clog2(LONG_TICKS + 1);
  localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_TICKS - 1);
  localparam logic [LW-1:0] HOLD_MAX  = LW'(LONG_TICKS);

  logic [NUM_CH-1:0][LW-1:0] hold;
  logic [NUM_CH-1:0][LW-1:0] hold_nxt;
  logic [NUM_CH-1:0]         long_set;

  // Counts ticks seen while level is high; a release being accepted clears it at once.
  always_comb begin
    hold_nxt = hold;
    long_set = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!level_out[i] || accept[i]) begin
        hold_nxt[i] = '0;
      end else if (tick && (hold[i] != HOLD_MAX)) begin
        hold_nxt[i] = hold[i] + LW'(1);
        long_set[i] = (hold[i] == HOLD_LAST);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold       <= '0;
      long_pulse <= '0;
    end else if (srst) begin
      hold       <= '0;
      long_pulse <= '0;
    end else begin
      hold       <= hold_nxt;
      long_pulse <= long_set;
    end
  end
`else
  logic unused_long_cfg;
  assign unused_long_cfg = ^LONG_TICKS;
  assign long_pulse      = '0;
`endif

endmodule

// File: tb/tb_debounce_input.sv
// Directed bench for debounce_input: a per-cycle vector table with continuous ticks,
// then hand sequences for slow ticks, bounce, async reset and long press.
`timescale 1ns/1ps

module tb_debounce_input;

  localparam int unsigned NUM_CH       = 8;
  localparam int unsigned STABLE_TICKS = 4;
  localparam int unsigned LONG_TICKS   = 20;
`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam bit LP_ON = 1'b1;
`else
  localparam bit LP_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              resetn;
  logic              srst;
  logic              tick;
  logic [NUM_CH-1:0] raw_in;
  logic [NUM_CH-1:0] level_out;
  logic [NUM_CH-1:0] press_pulse;
  logic [NUM_CH-1:0] release_pulse;
  logic [NUM_CH-1:0] long_pulse;

  int n_tests = 0;
  int n_fail  = 0;

  debounce_input #(
    .NUM_CH      (NUM_CH),
    .STABLE_TICKS(STABLE_TICKS),
    .LONG_TICKS  (LONG_TICKS)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .srst         (srst),
    .tick         (tick),
    .raw_in       (raw_in),
    .level_out    (level_out),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] raw;
    logic       tk;
    logic       sr;
    logic [7:0] lvl;
    logic [7:0] prs;
    logic [7:0] rls;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] quiet;

  task automatic add_n(input int n, input logic [7:0] raw, input logic tk, input logic sr,
                       input logic [7:0] lvl, input logic [7:0] prs, input logic [7:0] rls);
    vec_t v;
    v.raw = raw; v.tk = tk; v.sr = sr; v.lvl = lvl; v.prs = prs; v.rls = rls;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Nine idle cycles then one tick cycle; raw changes at the start of the period.
  task automatic period(input logic [7:0] raw);
    raw_in = raw;
    tick   = 1'b0;
    repeat (9) begin
      step();
      quiet = quiet | press_pulse | release_pulse;
    end
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  initial begin
    int lp_count;
    logic [7:0] b;

    // Vector table, one entry per clock with the raw input applied before that edge.
    add_n(5, 8'h09, 1, 0, 8'h00, 8'h00, 8'h00);
    add_n(1, 8'h09, 1, 0, 8'h09, 8'h09, 8'h00);
    add_n(1, 8'h09, 1, 0, 8'h09, 8'h00, 8'h00);
    add_n(5, 8'h00, 1, 0, 8'h09, 8'h00, 8'h00);
    add_n(1, 8'h00, 1, 0, 8'h00, 8'h00, 8'h09);
    add_n(1, 8'h00, 1, 0, 8'h00, 8'h00, 8'h00);
    add_n(5, 8'h04, 1, 0, 8'h00, 8'h00, 8'h00);
    add_n(1, 8'h04, 1, 1, 8'h00, 8'h00, 8'h00);
    add_n(5, 8'h04, 1, 0, 8'h00, 8'h00, 8'h00);
    add_n(1, 8'h04, 1, 0, 8'h04, 8'h04, 8'h00);
    add_n(1, 8'h04, 1, 0, 8'h04, 8'h00, 8'h00);
    add_n(7, 8'h00, 0, 0, 8'h04, 8'h00, 8'h00);
    add_n(1, 8'h00, 1, 0, 8'h04, 8'h00, 8'h00);
    add_n(1, 8'h00, 0, 0, 8'h04, 8'h00, 8'h00);
    add_n(2, 8'h00, 1, 0, 8'h04, 8'h00, 8'h00);
    add_n(1, 8'h00, 1, 0, 8'h00, 8'h00, 8'h04);
    add_n(1, 8'h00, 1, 0, 8'h00, 8'h00, 8'h00);
    add_n(2, 8'h10, 1, 0, 8'h00, 8'h00, 8'h00);
    add_n(3, 8'h00, 1, 0, 8'h00, 8'h00, 8'h00);
    add_n(5, 8'h10, 1, 0, 8'h00, 8'h00, 8'h00);
    add_n(1, 8'h10, 1, 0, 8'h10, 8'h10, 8'h00);
    add_n(1, 8'h10, 1, 0, 8'h10, 8'h00, 8'h00);

    // Reset with all pins high
    resetn = 1'b0; srst = 1'b0; tick = 1'b1; raw_in = 8'hFF; quiet = '0;
    repeat (3) step();
    chk("reset_level", level_out, 8'h00);
    chk("reset_press", press_pulse, 8'h00);
    chk("reset_release", release_pulse, 8'h00);
    chk("reset_long", long_pulse, 8'h00);

    resetn = 1'b1; tick = 1'b0;
    repeat (5) begin
      step();
      quiet = quiet | press_pulse | release_pulse | level_out;
    end
    raw_in = 8'h00;
    repeat (3) begin
      step();
      quiet = quiet | press_pulse | release_pulse | level_out;
    end
    chk("idle_after_reset", quiet, 8'h00);

    foreach (vecs[i]) begin
      raw_in = vecs[i].raw; tick = vecs[i].tk; srst = vecs[i].sr;
      step();
      chk($sformatf("v%0d_level", i), level_out, vecs[i].lvl);
      chk($sformatf("v%0d_press", i), press_pulse, vecs[i].prs);
      chk($sformatf("v%0d_release", i), release_pulse, vecs[i].rls);
      chk($sformatf("v%0d_long", i), long_pulse, 8'h00);
    end
    srst = 1'b0; tick = 1'b0;

    // Asynchronous reset takes effect between clock edges
    resetn = 1'b0;
    #2;
    chk("async_reset_level", level_out, 8'h00);
    step();
    resetn = 1'b1; raw_in = 8'h00;
    repeat (3) step();

    // Clean press on ch0 with a tick every 10 clocks
    quiet = '0;
    for (int t = 1; t <= 4; t++) begin
      period(8'h01);
      chk($sformatf("slow_t%0d_level", t), level_out, (t == 4) ? 8'h01 : 8'h00);
      chk($sformatf("slow_t%0d_press", t), press_pulse, (t == 4) ? 8'h01 : 8'h00);
    end
    step();
    chk("slow_press_clear", press_pulse, 8'h00);
    chk("slow_level_hold", level_out, 8'h01);

    // Bounce on ch1: 1,0,1,0 then steady 1
    for (int t = 1; t <= 8; t++) begin
      b = ((t == 2) || (t == 4)) ? 8'h01 : 8'h03;
      period(b);
      chk($sformatf("bounce_t%0d_level", t), level_out, (t == 8) ? 8'h03 : 8'h01);
      chk($sformatf("bounce_t%0d_press", t), press_pulse, (t == 8) ? 8'h02 : 8'h00);
    end
    step();
    chk("bounce_press_clear", press_pulse, 8'h00);
    chk("slow_idle_quiet", quiet, 8'h00);

    // Synchronous clear drops levels without a release strobe
    srst = 1'b1;
    step();
    srst = 1'b0;
    chk("srst_level", level_out, 8'h00);
    chk("srst_release", release_pulse, 8'h00);

    // Long press on ch2 with continuous ticks
    tick = 1'b1;
    for (int r = 0; r < 2; r++) begin
      raw_in = 8'h04;
      for (int c = 0; c < 6; c++) step();
      chk($sformatf("lp%0d_accept_level", r), level_out, 8'h04);
      chk($sformatf("lp%0d_accept_press", r), press_pulse, 8'h04);
      for (int k = 1; k <= 20; k++) begin
        step();
        chk($sformatf("lp%0d_k%0d_long", r, k), long_pulse, (LP_ON && k == 20) ? 8'h04 : 8'h00);
      end
      lp_count = 0;
      repeat (100) begin
        step();
        if (long_pulse != 8'h00) lp_count++;
      end
      chk($sformatf("lp%0d_no_repeat", r), 8'(lp_count), 8'h00);
      raw_in = 8'h00;
      for (int c = 0; c < 6; c++) step();
      chk($sformatf("lp%0d_release_level", r), level_out, 8'h00);
      chk($sformatf("lp%0d_release_pulse", r), release_pulse, 8'h04);
    end
    tick = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
